apb_vgachargen_bridge: RTL and testbench
========================================

APB_VGACHARGEN_BRIDGE -- requirements
Module: apb_vgachargen_bridge

Interface
REQ-001 SHALL have parameter none; address map fixed: char map 0x0000-0x095F, col map 0x1000-0x195F, char tiff 0x2000-0x2FFF (byte addresses, paddr_i[13:12] selects region, word index = paddr_i[11:2]).
REQ-002 SHALL have ports, clock and reset first: clk_i in 1 single clock; rst_i in 1 reset, synchronous, active-high.
REQ-003 psel_i in 1, penable_i in 1, pwrite_i in 1, paddr_i in 32, pwdata_i in 32, pstrb_i in 4: APB4 completer request.
REQ-004 pready_o out 1, prdata_o out 32, pslverr_o out 1: APB4 completer response.
REQ-005 mem_addr_o out 10 word index; mem_be_o out 4 byte enables; mem_wdata_o out 32 write data; shared by all three map ports.
REQ-006 char_map_we_o, col_map_we_o, char_tiff_we_o out 1 each: per-region write strobe.
REQ-007 char_map_rdata_i, col_map_rdata_i, char_tiff_rdata_i in 32 each: synchronous-RAM read data, valid one cycle after mem_addr_o.

Function
REQ-008 FSM states SHALL be IDLE, WR, RD, CAP, DONE.
REQ-009 IDLE: on psel_i & penable_i, latch paddr_i, pwrite_i, pwdata_i, pstrb_i; go WR (write), RD (read) or DONE with error flag (invalid address, see REQ-017).
REQ-010 WR: exactly one cycle, mem_addr_o/mem_wdata_o/mem_be_o = latched values, region we_o = 1 only if latched pstrb != 0; next DONE.
REQ-011 RD: mem_addr_o driven, all we_o = 0, mem_be_o = 0; next CAP.
REQ-012 CAP: region rdata_i registered into prdata_o at end of cycle; next DONE.
REQ-013 DONE: pready_o = 1 for exactly one cycle, pslverr_o = error flag; next IDLE unconditionally.
REQ-014 Latency: write = 3 cycles after penable_i rises (WR, DONE), read = 4 (RD, CAP, DONE), error = 2 (DONE); pready_o = 0 in every other state.
REQ-015 Request inputs SHALL be ignored outside IDLE; changes to paddr_i/pwdata_i during an access SHALL not affect it; penable_i without psel_i ignored.
REQ-016 Valid word index: char/col map 0..599, char tiff 0..1023; paddr_i[1:0] ignored.
REQ-017 Invalid address: region 3, or map index >= 600.
REQ-018 At most one we_o SHALL be high in any cycle; never high outside WR.
REQ-019 prdata_o SHALL hold its value until the next read capture; writes and errors leave it unchanged.

Reset
REQ-020 rst_i sampled high SHALL force IDLE, pready_o = 0, pslverr_o = 0, prdata_o = 0, mem_addr_o = 0, mem_be_o = 0, mem_wdata_o = 0, all we_o = 0 by the next edge.
REQ-021 Reset during WR/RD/CAP/DONE SHALL abort the transfer with no further we_o pulse and no pready_o; the master SHALL restart it.

Configuration
REQ-022 Macro APB_VGACHARGEN_BRIDGE_SLVERR_EN defined: invalid addresses complete in DONE with pslverr_o = 1, no memory access, prdata_o unchanged.
REQ-023 Macro undefined: pslverr_o tied 0; invalid writes go WR with all we_o = 0; invalid reads complete via RD/CAP with prdata_o = 0.

Verification
REQ-024 Write 0xA5A5_0001 to 0x1004 with pstrb 0xF -> col_map_we_o high one cycle, mem_addr_o = 1, mem_be_o = 0xF, pready_o 3 cycles after penable, pslverr_o = 0.
REQ-025 Read 0x0008 with char_map_rdata_i = 0x1234_5678 one cycle after mem_addr_o = 2 -> prdata_o = 0x1234_5678 with pready_o 4 cycles after penable.
REQ-026 Write 600 words 0..599 to char map then read back 0x0000..0x095C -> every read matches; last write index 599 at 0x095C.
REQ-027 With SLVERR_EN: write 0x0960 (index 600) and access 0x3000 -> pslverr_o = 1 at pready_o, no we_o pulse; without macro: pslverr_o = 0, read returns 0.
REQ-028 Write with pstrb 0x0 to 0x2000 -> no char_tiff_we_o, pready_o still after 3 cycles.
REQ-029 rst_i asserted in RD state -> next cycle IDLE, pready_o = 0, prdata_o = 0; following read of 0x2004 completes normally.

Source files
------------

// File: rtl/apb_vgachargen_bridge.sv
// rtl/apb_vgachargen_bridge.sv - APB4 completer bridging to VGA char map, colour map and char tiff RAMs
//
// Optional feature macro: APB_VGACHARGEN_BRIDGE_SLVERR_EN
//   defined   : invalid addresses finish straight away with pslverr_o = 1 and no memory access
//   undefined : pslverr_o is tied 0; invalid writes strobe nothing, invalid reads return 0
//
// Ports
//   clk_i, rst_i                      single clock, synchronous active-high reset
//   psel_i, penable_i, pwrite_i,
//   paddr_i, pwdata_i, pstrb_i        APB4 request
//   pready_o, prdata_o, pslverr_o     APB4 response
//   mem_addr_o, mem_be_o, mem_wdata_o shared RAM address / byte enables / write data
//   char_map_we_o, col_map_we_o,
//   char_tiff_we_o                    per-region write strobes
//   char_map_rdata_i, col_map_rdata_i,
//   char_tiff_rdata_i                 synchronous RAM read data (one cycle after address)
//
// Address map: paddr_i[13:12] = 0 char map (600 words), 1 col map (600 words),
// 2 char tiff (1024 words), 3 invalid; word index = paddr_i[11:2].

module apb_vgachargen_bridge (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic [9:0]  mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  output logic        char_map_we_o,
  output logic        col_map_we_o,
  output logic        char_tiff_we_o,
  input  logic [31:0] char_map_rdata_i,
  input  logic [31:0] col_map_rdata_i,
  input  logic [31:0] char_tiff_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;

  localparam logic [9:0] MAP_WORDS = 10'd600;

  state_t      state, state_nxt;

  logic [1:0]  region_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        bad_q;

  logic [1:0]  req_region;
  logic [9:0]  req_index;
  logic        req_bad;
  logic        req_start;
  logic        wr_ok;

  // Address bits outside the decoded window carry no meaning for this block.
  logic        unused_paddr;
  assign unused_paddr = ^{paddr_i[31:14], paddr_i[1:0]};

  assign req_region = paddr_i[13:12];
  assign req_index  = paddr_i[11:2];
  assign req_bad    = (req_region == 2'd3) ||
                      ((req_region != 2'd2) && (req_index >= MAP_WORDS));
  assign req_start  = psel_i && penable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      region_q <= 2'd0;
      addr_q   <= 10'd0;
      wdata_q  <= 32'd0;
      strb_q   <= 4'd0;
      bad_q    <= 1'b0;
      prdata_o <= 32'd0;
    end else begin
      state <= state_nxt;
      // The request is captured once; later changes on the bus cannot disturb it.
      if (state == IDLE && req_start) begin
        region_q <= req_region;
        addr_q   <= req_index;
        wdata_q  <= pwdata_i;
        strb_q   <= pstrb_i;
        bad_q    <= req_bad;
      end
      // RAM data for the address driven in RD is valid during CAP.
      if (state == CAP) begin
        if (bad_q) begin
          prdata_o <= 32'd0;
        end else begin
          case (region_q)
            2'd0:    prdata_o <= char_map_rdata_i;
            2'd1:    prdata_o <= col_map_rdata_i;
            2'd2:    prdata_o <= char_tiff_rdata_i;
            default: prdata_o <= 32'd0;
          endcase
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_start) begin
`ifdef APB_VGACHARGEN_BRIDGE_SLVERR_EN
          if (req_bad)       state_nxt = DONE;
          else if (pwrite_i) state_nxt = WR;
          else               state_nxt = RD;
`else
          if (pwrite_i) state_nxt = WR;
          else          state_nxt = RD;
`endif
        end
      end
      WR:      state_nxt = DONE;
      RD:      state_nxt = CAP;
      CAP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A strobe fires only for a valid address with at least one byte enabled,
  // and only in WR, so at most one region is ever written per cycle.
  assign wr_ok          = (state == WR) && !bad_q && (strb_q != 4'd0);
  assign char_map_we_o  = wr_ok && (region_q == 2'd0);
  assign col_map_we_o   = wr_ok && (region_q == 2'd1);
  assign char_tiff_we_o = wr_ok && (region_q == 2'd2);

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = (state == WR) ? strb_q : 4'd0;
  assign pready_o    = (state == DONE);

`ifdef APB_VGACHARGEN_BRIDGE_SLVERR_EN
  assign pslverr_o = (state == DONE) && bad_q;
`else
  assign pslverr_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// tb/tb_apb_vgachargen_bridge.sv - scoreboard bench for apb_vgachargen_bridge

module tb_apb_vgachargen_bridge;

`ifdef APB_VGACHARGEN_BRIDGE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0, pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o;
  logic [9:0]  mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        char_map_we_o, col_map_we_o, char_tiff_we_o;
  logic [31:0] char_map_rdata_i, col_map_rdata_i, char_tiff_rdata_i;

  apb_vgachargen_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .char_map_we_o(char_map_we_o), .col_map_we_o(col_map_we_o), .char_tiff_we_o(char_tiff_we_o),
    .char_map_rdata_i(char_map_rdata_i), .col_map_rdata_i(col_map_rdata_i),
    .char_tiff_rdata_i(char_tiff_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAMs written only through the DUT strobes.
  logic [31:0] ram [0:2][0:1023];
  // Bench-side expected memory contents, updated when stimulus is issued.
  logic [31:0] shd [0:2][0:1023];

  initial begin
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 1024; i++) begin
        ram[r][i] = '0;
        shd[r][i] = '0;
      end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  always @(posedge clk_i) begin
    if (char_map_we_o)  ram[0][mem_addr_o] <= merge(ram[0][mem_addr_o], mem_wdata_o, mem_be_o);
    if (col_map_we_o)   ram[1][mem_addr_o] <= merge(ram[1][mem_addr_o], mem_wdata_o, mem_be_o);
    if (char_tiff_we_o) ram[2][mem_addr_o] <= merge(ram[2][mem_addr_o], mem_wdata_o, mem_be_o);
    char_map_rdata_i  <= ram[0][mem_addr_o];
    col_map_rdata_i   <= ram[1][mem_addr_o];
    char_tiff_rdata_i <= ram[2][mem_addr_o];
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = '0;

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t        e, got_e;
    logic [1:0]  rg;
    logic [9:0]  idx;
    bit          bad, done;
    int          lat, nwe;
    logic [2:0]  we_vec, we_exp;
    rg  = addr[13:12];
    idx = addr[11:2];
    bad = (rg == 2'd3) || (rg != 2'd2 && idx >= 10'd600);
    if (bad && SLVERR_EN) begin
      e = '{rdata: last_rd, err: 1'b1, lat: 2, we_cnt: 0};
    end else if (wr) begin
      e = '{rdata: last_rd, err: 1'b0, lat: 3, we_cnt: (!bad && strb != 0) ? 1 : 0};
      if (!bad) shd[rg][idx] = merge(shd[rg][idx], data, strb);
    end else begin
      e = '{rdata: bad ? 32'd0 : shd[rg][idx], err: 1'b0, lat: 4, we_cnt: 0};
      last_rd = e.rdata;
    end
    sb.push_back(e);
    we_exp = 3'b001 << rg;

    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; pwrite_i = wr; paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    @(posedge clk_i); #1;
    penable_i = 1;
    lat = 1; nwe = 0; done = 0;
    while (!done && lat <= 10) begin
      @(negedge clk_i);
      we_vec = {char_tiff_we_o, col_map_we_o, char_map_we_o};
      if (we_vec != 3'b000) begin
        nwe++;
        chk("we_region", {29'd0, we_vec}, {29'd0, we_exp});
        chk("we_addr", {22'd0, mem_addr_o}, {22'd0, idx});
        chk("we_be", {28'd0, mem_be_o}, {28'd0, strb});
        chk("we_wdata", mem_wdata_o, data);
      end
      if (pready_o) begin
        done = 1;
      end else begin
        @(posedge clk_i); #1;
        // The access is latched by now; bus noise must not disturb it.
        if (lat == 1) begin
          paddr_i = $urandom; pwdata_i = $urandom; pstrb_i = 4'($urandom); pwrite_i = 1'($urandom);
        end
        lat++;
      end
    end
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      got_e = sb.pop_front();
      chk("latency", lat, got_e.lat);
      chk("pslverr", {31'd0, pslverr_o}, {31'd0, got_e.err});
      chk("prdata", prdata_o, got_e.rdata);
      chk("we_count", nwe, got_e.we_cnt);
    end
    @(posedge clk_i); #1;
    psel_i = 0; penable_i = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    chk("rst_pready", {31'd0, pready_o}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr_o}, 32'd0);
    chk("rst_prdata", prdata_o, 32'd0);
    chk("rst_addr", {22'd0, mem_addr_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_we", {29'd0, char_tiff_we_o, col_map_we_o, char_map_we_o}, 32'd0);

    xfer(1, 32'h0000_1004, 32'hA5A5_0001, 4'hF);
    xfer(0, 32'h0000_1004, 32'h0, 4'h0);
    xfer(1, 32'h0000_0008, 32'h1234_5678, 4'hF);
    xfer(0, 32'h0000_0008, 32'h0, 4'h0);
    xfer(1, 32'h0000_2010, 32'hFFFF_FFFF, 4'hF);
    xfer(1, 32'h0000_2011, 32'h1122_3344, 4'h5);
    xfer(0, 32'h0000_2010, 32'h0, 4'h0);
    xfer(1, 32'h0000_2004, 32'hCAFE_F00D, 4'hF);
    xfer(1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h0);
    xfer(0, 32'h0000_2000, 32'h0, 4'h0);
    xfer(1, 32'h0000_2FFC, 32'h0BAD_CAFE, 4'hF);
    xfer(0, 32'h0000_2FFC, 32'h0, 4'h0);
    xfer(1, 32'h0000_0960, 32'h5555_AAAA, 4'hF);
    xfer(1, 32'h0000_3000, 32'h6666_9999, 4'hF);
    xfer(0, 32'h0000_3000, 32'h0, 4'h0);
    xfer(0, 32'h0000_1960, 32'h0, 4'h0);
    xfer(0, 32'h0000_1004, 32'h0, 4'h0);

    // penable without psel must be ignored
    @(posedge clk_i); #1;
    penable_i = 1; pwrite_i = 1; paddr_i = 32'h0000_0004; pwdata_i = 32'h7777_7777; pstrb_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("nosel_pready", {31'd0, pready_o}, 32'd0);
      chk("nosel_we", {29'd0, char_tiff_we_o, col_map_we_o, char_map_we_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    penable_i = 0;

    // reset while in RD aborts the read
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h0000_0008;
    @(posedge clk_i); #1;
    penable_i = 1;
    @(posedge clk_i); #1;
    rst_i = 1; psel_i = 0; penable_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    last_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("abort_pready", {31'd0, pready_o}, 32'd0);
      chk("abort_prdata", prdata_o, 32'd0);
      chk("abort_we", {29'd0, char_tiff_we_o, col_map_we_o, char_map_we_o}, 32'd0);
    end
    chk("abort_addr", {22'd0, mem_addr_o}, 32'd0);
    xfer(0, 32'h0000_2004, 32'h0, 4'h0);

    for (int i = 0; i < 600; i++)
      xfer(1, 32'(i * 4), 32'(i) ^ 32'h3C00_0000 ^ (32'(i) << 16), 4'hF);
    for (int i = 0; i < 600; i++)
      xfer(0, 32'(i * 4), 32'h0, 4'h0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
